// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage between execute and writeback.
//            Latches the execute bus, waits for a variable-latency data SRAM
//            load response, aligns/extends the load data, and presents the
//            result to writeback. A response that arrives while writeback is
//            blocked is captured in a one-entry buffer so it is not lost.
// Ports    :
//   clk                  in   clock
//   reset                in   synchronous, active-high reset
//   ws_allowin           in   writeback can accept this cycle
//   ms_allowin           out  this stage can accept from execute
//   es_to_ms_valid       in   execute output valid
//   es_to_ms_bus         in   {ld_type,store_op,load_op,gr_we,dest,alu_result,pc}
//   ms_to_ws_valid       out  output valid to writeback
//   ms_to_ws_bus         out  {gr_we,dest,final_result,pc}
//   ms_to_ds_forward_bus out  {dep_need_stall,forward_enable,dest,result}
//   data_sram_data_ok    in   one-cycle pulse: load data valid
//   data_sram_rdata      in   load response word
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 75,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_forward_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;  // no instruction held
  localparam logic [1:0] S_RUN  = 2'd1;  // non-load, or load data in hand
  localparam logic [1:0] S_WAIT = 2'd2;  // load waiting for its response
  localparam logic [1:0] S_HOLD = 2'd3;  // response buffered, writeback blocked

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b101;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b110;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]                 state_q, state_d;
  logic                       ms_valid_q, ms_valid_d;
  logic                       rdata_buf_valid_q, rdata_buf_valid_d;
  logic [31:0]                rdata_buf_q, rdata_buf_d;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_q, es_bus_d;

  // --------------------------------------------------------------------------
  // Decoded fields of the latched execute bus
  // --------------------------------------------------------------------------
  logic [2:0]  ld_type;
  logic        store_op;
  logic        load_op;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        es_load_op;
  logic        unused_store_op;

  assign ld_type         = es_bus_q[74:72];
  assign store_op        = es_bus_q[71];
  assign load_op         = es_bus_q[70];
  assign gr_we           = es_bus_q[69];
  assign dest            = es_bus_q[68:64];
  assign alu_result      = es_bus_q[63:32];
  assign pc              = es_bus_q[31:0];
  assign es_load_op      = es_to_ms_bus[70];
  // Stores complete like ALU ops at this stage; the bit is carried but unread.
  assign unused_store_op = store_op;

  // --------------------------------------------------------------------------
  // Handshake / output-control logic
  // --------------------------------------------------------------------------
  logic data_ok_eff;
  logic ms_ready_go;
  logic dep_need_stall;
  logic forward_enable;

  always_comb begin
    // A response only belongs to us while a load is waiting for it; this
    // also drops stray responses after a reset that interrupted a WAIT.
    data_ok_eff    = data_sram_data_ok && (state_q == S_WAIT);
    ms_ready_go    = !load_op || data_ok_eff || rdata_buf_valid_q;
    ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = ms_valid_q && ms_ready_go;
    dep_need_stall = ms_valid_q && load_op && !ms_ready_go;
    forward_enable = ms_valid_q && gr_we && (dest != 5'd0);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d           = state_q;
    ms_valid_d        = ms_valid_q;
    rdata_buf_valid_d = rdata_buf_valid_q;
    rdata_buf_d       = rdata_buf_q;
    es_bus_d          = es_bus_q;

    if (ms_allowin) begin
      // Current instruction (if any) leaves; take whatever execute offers.
      // The buffer is never written here, even if a response lands now,
      // because the response is consumed combinationally this cycle.
      ms_valid_d        = es_to_ms_valid;
      es_bus_d          = es_to_ms_bus;
      rdata_buf_valid_d = 1'b0;
      if (es_to_ms_valid) begin
        state_d = es_load_op ? S_WAIT : S_RUN;
      end else begin
        state_d = S_IDLE;
      end
    end else if (data_ok_eff) begin
      // Response arrived but writeback is blocked: keep it for later.
      state_d           = S_HOLD;
      rdata_buf_d       = data_sram_rdata;
      rdata_buf_valid_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      ms_valid_q        <= 1'b0;
      rdata_buf_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      ms_valid_q        <= ms_valid_d;
      rdata_buf_valid_q <= rdata_buf_valid_d;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid flags.
  always_ff @(posedge clk) begin
    es_bus_q    <= es_bus_d;
    rdata_buf_q <= rdata_buf_d;
  end

  // --------------------------------------------------------------------------
  // Load data alignment and extension
  // --------------------------------------------------------------------------
  logic [31:0] raw_data;
  logic [1:0]  addr_lo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;
  logic [31:0] final_result;

  always_comb begin
    raw_data = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;
    addr_lo  = alu_result[1:0];

    case (addr_lo)
      2'd0:    byte_sel = raw_data[7:0];
      2'd1:    byte_sel = raw_data[15:8];
      2'd2:    byte_sel = raw_data[23:16];
      default: byte_sel = raw_data[31:24];
    endcase

    // Half-word select uses only addr bit 1; misalignment is not trapped here.
    half_sel = addr_lo[1] ? raw_data[31:16] : raw_data[15:0];

    case (ld_type)
      LD_LB:   load_result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  load_result = {24'd0, byte_sel};
      LD_LH:   load_result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  load_result = {16'd0, half_sel};
      LD_LW:   load_result = raw_data;
      default: load_result = raw_data;
    endcase

    final_result = load_op ? load_result : alu_result;
  end

  // --------------------------------------------------------------------------
  // Output buses
  // --------------------------------------------------------------------------
  assign ms_to_ws_bus         = {gr_we, dest, final_result, pc};
  assign ms_to_ds_forward_bus = {dep_need_stall, forward_enable, dest, final_result};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking testbench for mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_forward_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .ws_allowin           (ws_allowin),
    .ms_allowin           (ms_allowin),
    .es_to_ms_valid       (es_to_ms_valid),
    .es_to_ms_bus         (es_to_ms_bus),
    .ms_to_ws_valid       (ms_to_ws_valid),
    .ms_to_ws_bus         (ms_to_ws_bus),
    .ms_to_ds_forward_bus (ms_to_ds_forward_bus),
    .data_sram_data_ok    (data_sram_data_ok),
    .data_sram_rdata      (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control tuple: {ms_to_ws_valid, ms_allowin, dep_need_stall, forward_enable}
  logic [3:0]  ctl;
  logic [31:0] res;
  logic [31:0] fwd_res;
  assign ctl     = {ms_to_ws_valid, ms_allowin, ms_to_ds_forward_bus[38], ms_to_ds_forward_bus[37]};
  assign res     = ms_to_ws_bus[63:32];
  assign fwd_res = ms_to_ds_forward_bus[31:0];

  function automatic logic [74:0] mk_bus(input logic [2:0] lt, input logic st, input logic ld,
                                         input logic we, input logic [4:0] d,
                                         input logic [31:0] alu, input logic [31:0] pc);
    return {lt, st, ld, we, d, alu, pc};
  endfunction

  // Advance to just after the next rising edge (inputs are driven here).
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    step(); step();
    #1;
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL reset ctl{valid,allowin,stall,fen}: got %b want %b", ctl, 4'b0100);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h0000_1000);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if ({ctl, res, ms_to_ws_bus[68:64]} !== {4'b1101, 32'h12345678, 5'd5}) begin
      errors++;
      $display("FAIL alu ctl/res/dest: got %b %h %0d want 1101 12345678 5", ctl, res, ms_to_ws_bus[68:64]);
    end
    step();
    #1;
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL alu_drain ctl: got %b want 0100", ctl);
    end
  endtask

  // Load with two stall cycles, then the response, then drain.
  task automatic run_load(input string name, input logic [2:0] lt, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(lt, 1'b0, 1'b1, 1'b1, 5'd3, addr, 32'h0000_2000);
    step();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== 4'b0011) begin
        errors++;
        $display("FAIL %s stall%0d ctl: got %b want 0011", name, i, ctl);
      end
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    #1;
    checks++;
    if ({ctl, res, fwd_res} !== {4'b1101, exp, exp}) begin
      errors++;
      $display("FAIL %s result ctl/res/fwd: got %b %h %h want 1101 %h %h", name, ctl, res, fwd_res, exp, exp);
    end
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL %s drain ctl: got %b want 0100", name, ctl);
    end
  endtask

  task automatic test_loads();
    run_load("lb",        3'b001, 32'h0000_1003, 32'h80FF_FFFF, 32'hFFFF_FF80);
    run_load("lbu",       3'b101, 32'h0000_1003, 32'h80FF_FFFF, 32'h0000_0080);
    run_load("lb_b1",     3'b001, 32'h0000_1001, 32'h1122_7F44, 32'h0000_007F);
    run_load("lh_hi",     3'b010, 32'h0000_2002, 32'h9ABC_1234, 32'hFFFF_9ABC);
    run_load("lhu_hi",    3'b110, 32'h0000_2002, 32'h9ABC_1234, 32'h0000_9ABC);
    run_load("lhu_lo",    3'b110, 32'h0000_2000, 32'h9ABC_1234, 32'h0000_1234);
    run_load("lw",        3'b000, 32'h0000_2004, 32'hCAFE_BABE, 32'hCAFE_BABE);
    run_load("other_lw",  3'b111, 32'h0000_2001, 32'h8765_4321, 32'h8765_4321);
  endtask

  task automatic test_backpressure();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_3000, 32'h0000_3000);
    step();
    es_to_ms_valid    = 1'b0;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({ctl, res} !== {4'b1001, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL bp_arrive ctl/res: got %b %h want 1001 deadbeef", ctl, res);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      // A stray pulse while holding must not disturb the buffered word.
      data_sram_data_ok = (i == 1);
      data_sram_rdata   = 32'h0;
      #1;
      checks++;
      if ({ctl, res} !== {4'b1001, 32'hDEAD_BEEF}) begin
        errors++;
        $display("FAIL bp_hold%0d ctl/res: got %b %h want 1001 deadbeef", i, ctl, res);
      end
    end
    step();
    data_sram_data_ok = 1'b0;
    ws_allowin        = 1'b1;
    #1;
    checks++;
    if ({ctl, res} !== {4'b1101, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL bp_release ctl/res: got %b %h want 1101 deadbeef", ctl, res);
    end
    step();
    #1;
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL bp_single_transfer ctl: got %b want 0100", ctl);
    end
  endtask

  task automatic test_store_stall();
    ws_allowin     = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_4444, 32'h0000_4000);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if ({ctl, res} !== {4'b1000, 32'h0000_4444}) begin
      errors++;
      $display("FAIL store_blocked ctl/res: got %b %h want 1000 00004444", ctl, res);
    end
    ws_allowin = 1'b1;
    #1;
    checks++;
    if (ctl !== 4'b1100) begin
      errors++;
      $display("FAIL store_release ctl: got %b want 1100", ctl);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_5000, 32'h0000_5000);
    step();
    es_to_ms_valid = 1'b0;
    reset          = 1'b1;
    #1;
    checks++;
    if (ctl !== 4'b0011) begin
      errors++;
      $display("FAIL rst_wait pre ctl: got %b want 0011", ctl);
    end
    step();
    reset             = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_5555;
    #1;
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL rst_wait stray ctl: got %b want 0100", ctl);
    end
    step();
    data_sram_data_ok = 1'b0;
    #1;
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL rst_wait after ctl: got %b want 0100", ctl);
    end
  endtask

  task automatic test_back_to_back();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0000_6000, 32'h0000_6000);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if (ctl !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_wait ctl: got %b want 0010", ctl);
    end
    es_to_ms_valid    = 1'b1;
    es_to_ms_bus      = mk_bus(3'b000, 1'b0, 1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, 32'h0000_6004);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1122_3344;
    #1;
    checks++;
    if ({ctl, res} !== {4'b1100, 32'h1122_3344}) begin
      errors++;
      $display("FAIL b2b_load ctl/res: got %b %h want 1100 11223344", ctl, res);
    end
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #1;
    checks++;
    if ({ctl, res, ms_to_ds_forward_bus[36:32]} !== {4'b1101, 32'hCAFE_F00D, 5'd7}) begin
      errors++;
      $display("FAIL b2b_add ctl/res/dest: got %b %h %0d want 1101 cafef00d 7", ctl, res, ms_to_ds_forward_bus[36:32]);
    end
    step();
    #1;
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_drain ctl: got %b want 0100", ctl);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_backpressure();
    test_store_stall();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the writeback stage.
- Latches the execute-stage bus and waits for the data SRAM load response, which has variable latency.
- Aligns and extends load data (byte, half, word; signed or unsigned) and presents the result to writeback.
- Drives a forwarding/stall bus back to decode and buffers a response that arrives while writeback is blocked.

Parameters:
ES_TO_MS_BUS_WD, 75, execute-to-memory bus width: {ld_type[2:0] 74:72, store_op 71, load_op 70, gr_we 69, dest 68:64, alu_result 63:32, pc 31:0}
MS_TO_WS_BUS_WD, 70, memory-to-writeback bus width: {gr_we 69, dest 68:64, final_result 63:32, pc 31:0}
MS_TO_DS_BUS_WD, 39, forward bus width: {dep_need_stall 38, forward_enable 37, dest 36:32, result 31:0}

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ws_allowin  input  1  writeback can accept this cycle
ms_allowin  output  1  this stage can accept from execute
es_to_ms_valid  input  1  execute output valid
es_to_ms_bus  input  ES_TO_MS_BUS_WD  execute payload
ms_to_ws_valid  output  1  output valid to writeback
ms_to_ws_bus  output  MS_TO_WS_BUS_WD  writeback payload
ms_to_ds_forward_bus  output  MS_TO_DS_BUS_WD  forward/stall info to decode
data_sram_data_ok  input  1  one-cycle pulse: load data valid on data_sram_rdata
data_sram_rdata  input  32  load response word

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state:
  - ms_valid=0, state=IDLE, rdata_buf_valid=0.
  - Outputs: ms_to_ws_valid=0, ms_allowin=1, forward bus stall and enable bits=0.
  - Payload registers are not reset.
- Input handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - When ms_allowin is high: ms_valid <= es_to_ms_valid, and the bus register loads es_to_ms_bus.
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Ready-go: ms_ready_go = !load_op || data_sram_data_ok || rdata_buf_valid. Stores and ALU operations have zero extra latency.
- State machine:
  - IDLE: ms_valid=0.
  - RUN: valid, and the instruction is a non-load or its data is in hand.
  - WAIT: valid load with no data yet.
  - HOLD: data buffered, writeback blocked.
- State transitions:
  - IDLE/RUN -> WAIT on accepting a load.
  - IDLE/RUN -> RUN on accepting a non-load.
  - Any state -> IDLE when nothing is accepted and the current instruction leaves.
  - WAIT + data_ok + ws_allowin -> next accepted instruction's state. The data passes combinationally and is not buffered.
  - WAIT + data_ok + !ws_allowin -> HOLD. rdata_buf <= data_sram_rdata, rdata_buf_valid <= 1.
  - HOLD + ws_allowin -> next instruction's state, and rdata_buf_valid <= 0.
- Response rules:
  - data_sram_data_ok outside WAIT (IDLE, RUN, HOLD, or after reset) is ignored.
  - A response arriving after a reset mid-WAIT is dropped.
- Load data selection: raw = rdata_buf_valid ? rdata_buf : data_sram_rdata. a = alu_result[1:0].
- Load extension by ld_type:
  - 000 LW: raw.
  - 001 LB: sign-extended byte a.
  - 101 LBU: zero-extended byte a.
  - 010 LH: sign-extended half, selected by a[1].
  - 110 LHU: zero-extended half, selected by a[1].
  - Other codes: treated as LW.
- Misalignment is not checked here.
- Result: final_result = load_op ? extended load data : alu_result.
- Forward bus (fields as in MS_TO_DS_BUS_WD):
  - dep_need_stall = ms_valid && load_op && !ms_ready_go.
  - forward_enable = ms_valid && gr_we && (dest != 0).
  - result = final_result. It is meaningful only when dep_need_stall=0.
- Simultaneous events: a response and a new acceptance in the same cycle complete the old load and latch the new instruction. The buffer is never written in that cycle.

Test Plan:
- ALU passthrough: add with alu_result=0x12345678, dest=5, gr_we=1, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x12345678, forward_enable=1, dep_need_stall=0.
- LB sign extension: addr=0x1003, data_ok with rdata=0x80FFFFFF, two cycles after accept -> dep_need_stall=1 for 2 cycles, ms_allowin=0, then final_result=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- LH/LHU upper half: addr=0x2002, rdata=0x9ABC1234 -> LH gives 0xFFFF9ABC, LHU gives 0x00009ABC. Addr=0x2000 LHU gives 0x00001234.
- Writeback backpressure: LW, data_ok with 0xDEADBEEF while ws_allowin=0, then change data_sram_rdata to 0 and hold 3 cycles -> state HOLD, ms_to_ws_valid=1. Release -> final_result=0xDEADBEEF, one transfer only.
- Reset mid-WAIT: load accepted, reset pulsed, then stray data_ok -> ms_to_ws_valid stays 0, ms_allowin=1, no stall.
- dest=0 and back-to-back: LW to r0 followed by an add -> forward_enable=0 for the load. The add is accepted in the same cycle as data_ok, with no bubble.
